clk_mon_scheduler: RTL



---
 rtl/clk_mon_scheduler.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/clk_mon_scheduler.sv
// clk_mon_scheduler
// Shares one clock-rate measurement engine across NCLK test clocks. Channels
// are visited round-robin from an enable mask. For each channel the block
// steers the external mux, waits for it to settle, starts the engine, collects
// (or times out) the count, checks it against per-channel limits and updates
// the per-channel result, valid, fault and timeout registers.
module clk_mon_scheduler #(
  parameter int NCLK           = 16,
  parameter int CNT_W          = 32,
  parameter int WIN_W          = 24,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_MARGIN = 256,
  localparam int SEL_W         = (NCLK > 1) ? $clog2(NCLK) : 1
) (
  input  logic                  clk_ref,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [NCLK-1:0]       chan_mask,
  input  logic [WIN_W-1:0]      window_cycles,
  input  logic [NCLK*CNT_W-1:0] lim_lo,
  input  logic [NCLK*CNT_W-1:0] lim_hi,
  input  logic [NCLK-1:0]       fault_clr,
  output logic [SEL_W-1:0]      meas_sel,
  output logic                  meas_start,
  output logic [WIN_W-1:0]      meas_window,
  input  logic                  meas_done,
  input  logic [CNT_W-1:0]      meas_count,
  output logic [NCLK*CNT_W-1:0] rate_out,
  output logic [NCLK-1:0]       rate_valid,
  output logic [NCLK-1:0]       fault,
  output logic [NCLK-1:0]       timeout,
  output logic                  sweep_done,
  output logic                  busy
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Wide enough for the largest window plus the margin without wrapping.
  localparam int WAIT_W = WIN_W + $clog2(TIMEOUT_MARGIN + 1) + 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] MARGIN      = WAIT_W'(TIMEOUT_MARGIN);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    EVAL,
    NEXT
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [SEL_W-1:0]  ptr_reg;
  logic [SET_W-1:0]  settle_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_inc;
  logic [WAIT_W-1:0] wait_limit;
  logic [CNT_W-1:0]  cap_count_reg;
  logic              cap_ok_reg;

  // FSM strobes
  logic idle_go;
  logic start_go;
  logic take_done;
  logic take_timeout;
  logic do_eval;
  logic do_next;

  // Pointer search results
  logic [SEL_W-1:0] first_idx;
  logic             first_found;
  logic [SEL_W-1:0] after_idx;
  logic             after_found;

  // Per-channel decode
  logic [NCLK-1:0] eval_hit;
  logic [NCLK-1:0] tmo_hit;
  logic [NCLK-1:0] viol;
  logic [NCLK-1:0] fault_set;

  assign wait_inc   = wait_cnt_reg + 1'b1;
  assign wait_limit = WAIT_W'(meas_window) + MARGIN;
  assign busy       = (state_reg != IDLE);

  // Round-robin search: lowest set mask bit at or above ptr (used when
  // leaving IDLE) and strictly after ptr with ptr itself checked last (used
  // in NEXT, so a single-channel mask keeps selecting the same channel).
  always_comb begin : ptr_search
    logic [SEL_W-1:0] idx;
    idx         = '0;
    first_idx   = ptr_reg;
    first_found = 1'b0;
    after_idx   = ptr_reg;
    after_found = 1'b0;
    for (int k = 0; k < NCLK; k++) begin
      idx = SEL_W'((int'(ptr_reg) + k) % NCLK);
      if (!first_found && chan_mask[idx]) begin
        first_found = 1'b1;
        first_idx   = idx;
      end
    end
    for (int k = 1; k <= NCLK; k++) begin
      idx = SEL_W'((int'(ptr_reg) + k) % NCLK);
      if (!after_found && chan_mask[idx]) begin
        after_found = 1'b1;
        after_idx   = idx;
      end
    end
  end

  // Per-channel limit check and one-hot strobes for the result registers.
  generate
    for (genvar gi = 0; gi < NCLK; gi++) begin : g_chan
      logic [CNT_W-1:0] lo;
      logic [CNT_W-1:0] hi;
      assign lo            = lim_lo[gi*CNT_W +: CNT_W];
      assign hi            = lim_hi[gi*CNT_W +: CNT_W];
      // A zero upper limit means the channel is not range-checked.
      assign viol[gi]      = (hi != '0) && ((cap_count_reg < lo) || (cap_count_reg > hi));
      assign eval_hit[gi]  = do_eval && (ptr_reg == SEL_W'(gi));
      assign tmo_hit[gi]   = take_timeout && (ptr_reg == SEL_W'(gi));
      assign fault_set[gi] = tmo_hit[gi] || (eval_hit[gi] && viol[gi]);
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk_ref) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state and strobe decode; dropping enable aborts settle/measure.
  always_comb begin
    state_next   = state_reg;
    idle_go      = 1'b0;
    start_go     = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    do_eval      = 1'b0;
    do_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && first_found) begin
          idle_go    = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (settle_cnt_reg == SETTLE_LAST) begin
          start_go   = 1'b1;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (meas_done) begin
          take_done  = 1'b1;
          state_next = EVAL;
        end else if (wait_inc == wait_limit) begin
          take_timeout = 1'b1;
          state_next   = EVAL;
        end
      end
      EVAL: begin
        do_eval    = 1'b1;
        state_next = NEXT;
      end
      NEXT: begin
        do_next    = 1'b1;
        state_next = (enable && after_found) ? SETTLE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Scheduler datapath: pointer, mux select, counters, start pulse, capture.
  always_ff @(posedge clk_ref) begin
    if (!aresetn) begin
      ptr_reg        <= '0;
      meas_sel       <= '0;
      settle_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
      meas_window    <= '0;
      meas_start     <= 1'b0;
      sweep_done     <= 1'b0;
      cap_count_reg  <= '0;
      cap_ok_reg     <= 1'b0;
    end else begin
      meas_start <= start_go;
      sweep_done <= 1'b0;

      if (state_reg == SETTLE && state_next == SETTLE) begin
        settle_cnt_reg <= settle_cnt_reg + 1'b1;
      end else begin
        settle_cnt_reg <= '0;
      end

      if (start_go) begin
        meas_window  <= window_cycles;
        wait_cnt_reg <= '0;
      end else if (state_reg == MEASURE) begin
        wait_cnt_reg <= wait_inc;
      end

      if (take_done) begin
        cap_count_reg <= meas_count;
        cap_ok_reg    <= 1'b1;
      end else if (take_timeout) begin
        cap_count_reg <= '0;
        cap_ok_reg    <= 1'b0;
      end

      if (idle_go) begin
        ptr_reg  <= first_idx;
        meas_sel <= first_idx;
      end

      // A wrap (or staying put) means every enabled channel has been visited.
      if (do_next && after_found) begin
        ptr_reg    <= after_idx;
        meas_sel   <= after_idx;
        sweep_done <= (after_idx <= ptr_reg);
      end
    end
  end

  // Per-channel result, valid, sticky fault and timeout registers.
  always_ff @(posedge clk_ref) begin
    if (!aresetn) begin
      rate_out   <= '0;
      rate_valid <= '0;
      fault      <= '0;
      timeout    <= '0;
    end else begin
      // A new fault takes priority over a clear in the same cycle.
      fault <= (fault & ~fault_clr) | fault_set;
      for (int i = 0; i < NCLK; i++) begin
        if (eval_hit[i]) begin
          rate_out[i*CNT_W +: CNT_W] <= cap_count_reg;
          rate_valid[i]              <= 1'b1;
          if (cap_ok_reg) begin
            timeout[i] <= 1'b0;
          end
        end
        if (tmo_hit[i]) begin
          timeout[i] <= 1'b1;
        end
      end
    end
  end

endmodule
